uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
- Parametrised successor UART receiver for the motherboard/daughtercard serial links.
- Configurable data width, parity mode, stop-bit count and bit period.
- Adds majority-vote bit sampling, false-start rejection, framing-error detection and a busy flag.
- Armed per transfer by start_rx. Reports a registered data word plus sticky status flags that the bus-side logic polls.

Parameters:
- CLKS_PER_BIT, 8, clock cycles per UART bit; even, >= 4.
- DATA_BITS, 8, data bits per frame, 5..9, LSB first.
- PARITY_MODE, 1, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 2, stop bits per frame, 1..2.
- TIMEOUT_CYCLES, 2000, cycles allowed from arm to start-bit detection.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- din  in  1  serial line, asynchronous to clk, idles high.
- start_rx  in  1  arm request; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- is_byte_valid  out  1  sticky; frame received with good parity and good stop bits.
- is_data_corrupt  out  1  sticky; parity mismatch.
- is_frame_error  out  1  sticky; any stop-bit vote low.
- is_rx_timeout  out  1  sticky; no start bit within TIMEOUT_CYCLES.
- dout  out  DATA_BITS  last captured data word.

Behaviour:
- Reset: state IDLE; all flags 0; dout 0; counters 0; din_ff1/ff2/ff3 reset to 1, so no spurious fall is detected.
- Sync and edge detect:
  - din -> ff1 -> ff2 -> ff3.
  - din_fall = ~ff2 & ff3.
  - Vote = majority of ff2 over the current cycle and the two previous cycles.
- HALF = CLKS_PER_BIT/2. F = 1 + DATA_BITS + (PARITY_MODE != 0) + STOP_BITS.
- States: IDLE, WAIT_START, START_CHECK, DATA, PARITY, STOP, DONE. PARITY is skipped when PARITY_MODE = 0.
- IDLE:
  - If start_rx: clear all four flags and dout, clear timeout counter, go to WAIT_START.
  - start_rx in any other state is ignored.
- WAIT_START:
  - din_fall at cycle t -> clear bit timer, go to START_CHECK.
  - Timeout counter reaching TIMEOUT_CYCLES-1 -> set is_rx_timeout, go to IDLE.
  - din_fall and timeout in the same cycle: din_fall wins.
- Center ticks: start-bit center at t+HALF; bit i (i = 1..F-1) center at t+HALF+i*CLKS_PER_BIT.
- START_CHECK at start center:
  - Vote 0 -> go to DATA.
  - Vote 1 (false start, glitch) -> return to WAIT_START; timeout counter is NOT cleared.
- DATA: at each center, shift the vote into an internal DATA_BITS shift register, LSB first. After DATA_BITS bits go to PARITY or STOP.
- PARITY: capture the vote.
  - Odd mode: error if XOR(data, parity) = 0.
  - Even mode: error if XOR(data, parity) = 1.
- STOP: any stop vote of 0 flags a frame error. Other stop votes are still sampled; no early exit.
- DONE, exactly 1 cycle after the last stop center, i.e. t+HALF+(F-1)*CLKS_PER_BIT+1:
  - dout <= shift register.
  - is_data_corrupt <= parity error.
  - is_frame_error <= stop error.
  - is_byte_valid <= neither error.
  - Then go to IDLE.
- Defaults: flags visible at cycle t+93.
- Flags and dout hold until the next accepted start_rx.
- Widths: bit timer $clog2(CLKS_PER_BIT); bit counter $clog2(F+1); timeout counter $clog2(TIMEOUT_CYCLES+1). No wrap-around occurs inside a frame.
- rst_n asserted mid-frame: immediate return to reset values; the partial frame is discarded.

Decomposition:
- Package uart_pkg: PARITY_NONE/ODD/EVEN constants, state enum encoding, function uart_frame_bits(DATA_BITS, PARITY_MODE, STOP_BITS).
- Sub-module uart_bit_sampler: 3-flop synchroniser, din_fall, 3-sample majority vote. Ports clk, rst_n, din, din_fall, vote.

Test Plan:
- Defaults, start_rx, then send 0xA5 with odd parity bit 1 and two stops -> dout = 0xA5, is_byte_valid = 1 at t+93, other flags 0, busy falls the same cycle.
- Same frame with parity bit 0 -> is_data_corrupt = 1, is_byte_valid = 0, dout = 0xA5.
- Second stop bit driven 0 -> is_frame_error = 1, is_byte_valid = 0.
- Arm, hold din high for 2000 cycles -> is_rx_timeout = 1 exactly 2000 cycles after arm, state IDLE.
- 2-cycle low glitch, then a real frame 0x3C -> glitch rejected, dout = 0x3C valid. A 1-cycle low pulse on a mid-data bit does not change the captured bit.
- Parameter sweep DATA_BITS = 7, PARITY_MODE = 2, STOP_BITS = 1, CLKS_PER_BIT = 16 sending 0x55 -> dout = 0x55 valid at t+8+9*16+1. rst_n pulsed mid-frame -> all outputs 0, busy = 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants, FSM encoding and frame-length helper for the parametrised UART receiver.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_WAIT_START  = 3'd1,
        ST_START_CHECK = 3'd2,
        ST_DATA        = 3'd3,
        ST_PARITY      = 3'd4,
        ST_STOP        = 3'd5,
        ST_DONE        = 3'd6
    } state_t;

    // Total bits on the wire per frame: start + data + optional parity + stops.
    function automatic int uart_frame_bits(input int data_bits, input int parity_mode,
                                           input int stop_bits);
        return 1 + data_bits + ((parity_mode != PARITY_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Synchronises the serial line, flags falling edges and produces a 3-sample majority vote.
module uart_bit_sampler (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic din_fall,
    output logic vote
);

    logic r_ff1, r_ff2, r_ff3, r_ff4;

    // Flops reset high so an idle line never looks like a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ff1 <= 1'b1;
            r_ff2 <= 1'b1;
            r_ff3 <= 1'b1;
            r_ff4 <= 1'b1;
        end else begin
            r_ff1 <= din;
            r_ff2 <= r_ff1;
            r_ff3 <= r_ff2;
            r_ff4 <= r_ff3;
        end
    end

    assign din_fall = ~r_ff2 & r_ff3;
    // r_ff3/r_ff4 are the two previous cycles of r_ff2.
    assign vote     = (r_ff2 & r_ff3) | (r_ff2 & r_ff4) | (r_ff3 & r_ff4);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: armed per transfer, majority-vote sampling, sticky status flags.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 8,
    parameter int DATA_BITS      = 8,
    parameter int PARITY_MODE    = 1,
    parameter int STOP_BITS      = 2,
    parameter int TIMEOUT_CYCLES = 2000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 din,
    input  logic                 start_rx,
    output logic                 busy,
    output logic                 is_byte_valid,
    output logic                 is_data_corrupt,
    output logic                 is_frame_error,
    output logic                 is_rx_timeout,
    output logic [DATA_BITS-1:0] dout,
    output state_t               dbg_state
);

    localparam int HALF       = CLKS_PER_BIT / 2;
    localparam int FRAME_BITS = uart_frame_bits(DATA_BITS, PARITY_MODE, STOP_BITS);
    localparam int TMR_W      = $clog2(CLKS_PER_BIT);
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);
    localparam int TO_W       = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [TMR_W-1:0] HALF_LAST = TMR_W'(HALF - 1);
    localparam logic [TMR_W-1:0] BIT_LAST  = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    state_t               r_state, w_next;
    logic [TMR_W-1:0]     r_bit_timer;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic [TO_W-1:0]      r_to_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_dout;
    logic                 r_par_err, r_stop_err;
    logic                 r_valid, r_corrupt, r_frame, r_timeout;
    logic                 w_din_fall, w_vote, w_center, w_timeout;

    uart_bit_sampler u_sampler (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .din_fall (w_din_fall),
        .vote     (w_vote)
    );

    // The start bit is checked half a bit after the edge; every later bit one full period on.
    assign w_center  = (r_state == ST_START_CHECK) ? (r_bit_timer == HALF_LAST)
                                                   : (r_bit_timer == BIT_LAST);
    assign w_timeout = (r_to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:        if (start_rx) w_next = ST_WAIT_START;
            ST_WAIT_START: begin
                if (w_din_fall)     w_next = ST_START_CHECK;
                else if (w_timeout) w_next = ST_IDLE;
            end
            ST_START_CHECK: if (w_center) w_next = w_vote ? ST_WAIT_START : ST_DATA;
            ST_DATA: begin
                if (w_center && (r_bit_cnt == DATA_LAST))
                    w_next = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY:      if (w_center) w_next = ST_STOP;
            ST_STOP:        if (w_center && (r_bit_cnt == STOP_LAST)) w_next = ST_DONE;
            ST_DONE:        w_next = ST_IDLE;
            default:        w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_timer <= '0;
            r_bit_cnt   <= '0;
            r_to_cnt    <= '0;
            r_shift     <= '0;
            r_dout      <= '0;
            r_par_err   <= 1'b0;
            r_stop_err  <= 1'b0;
            r_valid     <= 1'b0;
            r_corrupt   <= 1'b0;
            r_frame     <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_rx) begin
                        r_to_cnt   <= '0;
                        r_dout     <= '0;
                        r_par_err  <= 1'b0;
                        r_stop_err <= 1'b0;
                        r_valid    <= 1'b0;
                        r_corrupt  <= 1'b0;
                        r_frame    <= 1'b0;
                        r_timeout  <= 1'b0;
                    end
                end
                ST_WAIT_START: begin
                    if (w_din_fall)     r_bit_timer <= '0;
                    else if (w_timeout) r_timeout   <= 1'b1;
                    else                r_to_cnt    <= r_to_cnt + 1'b1;
                end
                ST_START_CHECK: begin
                    if (w_center) begin
                        r_bit_timer <= '0;
                        r_bit_cnt   <= '0;
                    end else begin
                        r_bit_timer <= r_bit_timer + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_center) begin
                        r_bit_timer <= '0;
                        r_shift     <= {w_vote, r_shift[DATA_BITS-1:1]};
                        r_bit_cnt   <= (r_bit_cnt == DATA_LAST) ? '0 : r_bit_cnt + 1'b1;
                    end else begin
                        r_bit_timer <= r_bit_timer + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (w_center) begin
                        r_bit_timer <= '0;
                        r_par_err   <= (PARITY_MODE == PARITY_ODD) ? ~(^r_shift ^ w_vote)
                                                                   :  (^r_shift ^ w_vote);
                    end else begin
                        r_bit_timer <= r_bit_timer + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (w_center) begin
                        r_bit_timer <= '0;
                        r_bit_cnt   <= r_bit_cnt + 1'b1;
                        if (!w_vote) r_stop_err <= 1'b1;
                    end else begin
                        r_bit_timer <= r_bit_timer + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_dout    <= r_shift;
                    r_corrupt <= r_par_err;
                    r_frame   <= r_stop_err;
                    r_valid   <= ~(r_par_err | r_stop_err);
                end
                default: ;
            endcase
        end
    end

    assign busy            = (r_state != ST_IDLE);
    assign is_byte_valid   = r_valid;
    assign is_data_corrupt = r_corrupt;
    assign is_frame_error  = r_frame;
    assign is_rx_timeout   = r_timeout;
    assign dout            = r_dout;
    assign dbg_state       = r_state;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: default 8O2 instance plus a 7E1 / 16-clock instance.
module tb_uart_rx_param;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       din = 1'b1, start_rx = 1'b0;
    logic       din2 = 1'b1, start_rx2 = 1'b0;
    logic       busy, valid, corrupt, ferr, tout;
    logic       busy2, valid2, corrupt2, ferr2, tout2;
    logic [7:0] dout;
    logic [6:0] dout2;
    state_t     dbg_state, dbg_state2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_rx_param dut (
        .clk(clk), .rst_n(rst_n), .din(din), .start_rx(start_rx),
        .busy(busy), .is_byte_valid(valid), .is_data_corrupt(corrupt),
        .is_frame_error(ferr), .is_rx_timeout(tout), .dout(dout), .dbg_state(dbg_state)
    );

    uart_rx_param #(
        .CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(1), .TIMEOUT_CYCLES(2000)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .din(din2), .start_rx(start_rx2),
        .busy(busy2), .is_byte_valid(valid2), .is_data_corrupt(corrupt2),
        .is_frame_error(ferr2), .is_rx_timeout(tout2), .dout(dout2), .dbg_state(dbg_state2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // {busy, valid, corrupt, frame_error, timeout}
    function automatic logic [4:0] status(input int which);
        if (which == 0) return {busy, valid, corrupt, ferr, tout};
        return {busy2, valid2, corrupt2, ferr2, tout2};
    endfunction

    function automatic logic [31:0] get_dout(input int which);
        if (which == 0) return 32'(dout);
        return 32'(dout2);
    endfunction

    task automatic drive(input int which, input logic v);
        if (which == 0) din = v;
        else            din2 = v;
    endtask

    task automatic arm(input string tag, input int which);
        @(negedge clk);
        if (which == 0) start_rx = 1'b1; else start_rx2 = 1'b1;
        @(negedge clk);
        start_rx = 1'b0;
        start_rx2 = 1'b0;
        check({tag, "_arm"}, 32'(status(which)), 32'h10);
        repeat (2) @(negedge clk);
    endtask

    // Bits are driven from negedges; the line fall reaches din_fall three edges later,
    // so flags must appear at offset 3 + HALF + (F-1)*CLKS_PER_BIT + 1 from the first drive.
    task automatic run_frame(input string tag, input int which, input logic [31:0] bits,
                             input int nbits, input int cpb, input int glitch_k,
                             input logic [31:0] exp_dout, input logic [2:0] exp_flags);
        int done_k;
        done_k = 4 + cpb / 2 + (nbits - 1) * cpb;
        for (int k = 0; k <= nbits * cpb; k++) begin
            @(negedge clk);
            if (k == glitch_k)        drive(which, 1'b0);
            else if (k < nbits * cpb) drive(which, bits[k / cpb]);
            else                      drive(which, 1'b1);
            if (k == done_k - 1)
                check({tag, "_pre"}, 32'(status(which)), 32'h10);
            if (k == done_k) begin
                check({tag, "_flags"}, 32'(status(which)), 32'({1'b0, exp_flags, 1'b0}));
                check({tag, "_dout"}, get_dout(which), exp_dout);
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_status", 32'(status(0)), 32'h0);
        check("rst_dout", get_dout(0), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_status", 32'(status(0)), 32'h0);
        check("post_rst_status2", 32'(status(1)), 32'h0);
        check("post_rst_state", 32'(dbg_state), 32'(ST_IDLE));

        // 0xA5, odd parity 1, two stops
        arm("a5_ok", 0);
        run_frame("a5_ok", 0, 32'hF4A, 12, 8, -1, 32'hA5, 3'b100);
        arm("a5_par", 0);
        run_frame("a5_par", 0, 32'hD4A, 12, 8, -1, 32'hA5, 3'b010);
        arm("a5_stop", 0);
        run_frame("a5_stop", 0, 32'h74A, 12, 8, -1, 32'hA5, 3'b001);
        // 0x00 with wrong parity and second stop low: both errors
        arm("zero_both", 0);
        run_frame("zero_both", 0, 32'h400, 12, 8, -1, 32'h00, 3'b011);

        // Timeout: flag exactly 2000 edges after the arming edge
        @(negedge clk);
        start_rx = 1'b1;
        @(negedge clk);
        start_rx = 1'b0;
        check("to_clear", 32'(status(0)), 32'h10);
        repeat (1999) @(negedge clk);
        check("to_before", 32'(status(0)), 32'h10);
        @(negedge clk);
        check("to_status", 32'(status(0)), 32'h01);
        check("to_state", 32'(dbg_state), 32'(ST_IDLE));
        check("to_dout", get_dout(0), 32'h0);

        // 2-cycle glitch rejected, then 0x3C with a 1-cycle dip inside a data '1'
        arm("glitch", 0);
        @(negedge clk);
        din = 1'b0;
        repeat (2) @(negedge clk);
        din = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_status", 32'(status(0)), 32'h10);
        check("glitch_state", 32'(dbg_state), 32'(ST_WAIT_START));
        run_frame("x3c", 0, 32'hE78, 12, 8, 28, 32'h3C, 3'b100);

        // 7 data bits, even parity, 1 stop, 16 clocks per bit
        arm("p55", 1);
        run_frame("p55", 1, 32'h2AA, 10, 16, -1, 32'h55, 3'b100);

        // Asynchronous reset in the middle of a frame
        arm("mid", 1);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            din2 = k < 16 ? 1'b0 : 1'b1;
        end
        check("mid_busy", 32'(status(1)), 32'h10);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_status2", 32'(status(1)), 32'h0);
        check("mid_rst_dout2", get_dout(1), 32'h0);
        check("mid_rst_status1", 32'(status(0)), 32'h0);
        check("mid_rst_dout1", get_dout(0), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        din2 = 1'b1;
        repeat (5) @(negedge clk);
        check("mid_after_status2", 32'(status(1)), 32'h0);
        check("mid_after_state2", 32'(dbg_state2), 32'(ST_IDLE));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
